// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider
//  Purpose  : Sequential unsigned restoring divider. It computes one quotient
//             bit per cycle, MSB first. A zero divisor skips the iterations
//             and reports an all-ones quotient together with div_by_zero.
//  Revision : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int            CW     = $clog2(DW + 1);
    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(DW - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_dvd;    // dividend; it shifts left so the next bit is always the MSB
    logic [VW-1:0] r_dvs;
    logic [VW-1:0] r_prem;   // partial remainder
    logic [DW-1:0] r_qacc;   // quotient accumulator
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dbz;

    logic [VW:0]   w_trial;
    logic          w_ge;
    logic [VW-1:0] w_diff;
    logic [VW-1:0] w_prem_next;
    logic [DW-1:0] w_q_next;

    // One restoring step. When trial >= divisor the difference is smaller
    // than the divisor, so the low VW bits of the subtraction hold it exactly.
    // When trial < divisor the trial itself is smaller than the divisor, so
    // it also fits in VW bits.
    always_comb begin
        w_trial     = {r_prem, r_dvd[DW-1]};
        w_ge        = (w_trial >= {1'b0, r_dvs});
        w_diff      = w_trial[VW-1:0] - r_dvs;
        w_prem_next = w_ge ? w_diff : w_trial[VW-1:0];
        w_q_next    = (r_qacc << 1) | DW'(w_ge);
    end

    // Control FSM and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_prem  <= '0;
            r_qacc  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_cnt   <= '0;
                        r_prem  <= '0;
                        r_qacc  <= '0;
                        r_state <= (divisor == '0) ? c_DONE : c_RUN;
                    end
                end
                c_RUN: begin
                    r_dvd  <= r_dvd << 1;
                    r_prem <= w_prem_next;
                    r_qacc <= w_q_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Result registers. They load only on entry to DONE and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (r_state == c_IDLE && start && divisor == '0) begin
            r_quot <= '1;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
        end else if (r_state == c_RUN && r_cnt == c_LAST) begin
            r_quot <= w_q_next;
            r_rem  <= w_prem_next;
            r_dbz  <= 1'b0;
        end
    end

    assign ready       = (r_state == c_IDLE);
    assign busy        = (r_state == c_RUN);
    assign done        = (r_state == c_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_restoring_divider
//  Purpose  : Scoreboard bench for restoring_divider (DW=8, VW=4). Stimulus
//             pushes the expected results. A negedge monitor pops and compares
//             them on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct {
        int q;
        int r;
        int z;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   done_times[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   done_cnt = 0;
    bit   mon_en  = 0;
    logic rst_d   = 1'b0;
    int   hold_q  = 0;
    int   hold_r  = 0;
    int   hold_z  = 0;

    restoring_divider #(.DW(8), .VW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count posedges and remember whether reset was applied at the last edge.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: one-hot status, scoreboard on done, and holding of the outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (rst_d) begin
                hold_q = 0;
                hold_r = 0;
                hold_z = 0;
            end
            chk("status_onehot_le1", (int'(ready) + int'(busy) + int'(done)) <= 1 ? 1 : 0, 1);
            if (done) begin
                done_cnt++;
                done_times.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done (cyc=%0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), e.q);
                    chk("remainder", int'(remainder), e.r);
                    chk("div_by_zero", int'(div_by_zero), e.z);
                    chk("done_cycle", cyc, e.cyc);
                    hold_q = e.q;
                    hold_r = e.r;
                    hold_z = e.z;
                end
            end else begin
                chk("hold_quotient", int'(quotient), hold_q);
                chk("hold_remainder", int'(remainder), hold_r);
                chk("hold_div_by_zero", int'(div_by_zero), hold_z);
            end
        end
    end

    // Wait for ready, then present one start pulse. This optionally pushes the expected result.
    task automatic issue(input int a, input int b, input int eq, input int er,
                         input int ez, input bit push);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_issue", int'(ready), 1);
        dividend = a[7:0];
        divisor  = b[3:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.z   = ez;
            e.cyc = cyc + ((b == 0) ? 0 : 8);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", int'(ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        mon_en = 1'b1;

        // start=1 while rst=1: reset wins
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_over_start_ready", int'(ready), 1);

        // 200/7 = 28 r 4
        issue(200, 7, 28, 4, 0, 1);
        drain();

        // 255/1 followed back-to-back by 5/9; the done pulses are 10 cycles apart
        issue(255, 1, 255, 0, 0, 1);
        issue(5, 9, 0, 5, 0, 1);
        drain();
        chk("back_to_back_spacing",
            done_times[done_times.size()-1] - done_times[done_times.size()-2], 10);

        // 100/0: one-cycle latency, all-ones quotient
        issue(100, 0, 255, 0, 1, 1);
        drain();

        // 200/7 with start held and operands changed mid-run
        n0 = done_cnt;
        issue(200, 7, 28, 4, 0, 1);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        repeat (4) @(negedge clk);
        dividend = 8'd99;
        divisor  = 4'd2;
        repeat (2) @(negedge clk);
        chk("busy_mid_run", int'(busy), 1);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("single_done_pulse", done_cnt - n0, 1);

        // Reset in RUN cycle 4 of 255/15 aborts with no done
        n0 = done_cnt;
        issue(255, 15, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - n0, 0);
        issue(15, 15, 1, 0, 0, 1);
        drain();

        // All operand pairs
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) issue(a, b, 255, 0, 1, 1);
                else        issue(a, b, a / b, a % b, 0, 1);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
